// File: rtl/card_lock_ctrl.sv
// Hotel door card lock: per-class rolling LFSR codes, open hold timer,
// and brute-force lockout after consecutive refused reads.
module card_lock_ctrl #(
    parameter int                CODE_W         = 16,
    parameter int                NUM_CLASSES    = 2,
    parameter logic [CODE_W-1:0] LFSR_TAPS      = 16'h8016,
    parameter logic [CODE_W-1:0] RESET_CODE     = 16'h8001,
    parameter int                OPEN_CYCLES    = 50,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 1000,
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              card_strobe,
    input  logic [CLS_W-1:0]  card_class,
    input  logic              card_is_reset,
    input  logic [CODE_W-1:0] card_code,
    output logic              unlock,
    output logic [CLS_W-1:0]  grant_class,
    output logic              reject,
    output logic              locked_out
);

    localparam int OW = $clog2(OPEN_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;

    localparam logic [OW-1:0] OPEN_LD = OW'(OPEN_CYCLES);
    localparam logic [OW-1:0] OPEN_1  = OW'(1);
    localparam logic [LW-1:0] LOCK_LD = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_1  = LW'(1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_1  = FW'(1);

    logic [CODE_W-1:0] lfsr [NUM_CLASSES];
    logic [CODE_W-1:0] cur  [NUM_CLASSES];
    logic [FW-1:0]     fail_cnt;
    logic [OW-1:0]     open_cnt;
    logic [LW-1:0]     lock_cnt;

    logic              cls_ok;
    logic [CODE_W-1:0] sel_lfsr;
    logic [CODE_W-1:0] sel_cur;
    logic [CODE_W-1:0] nxt_lfsr;
    logic              d0;
    logic              do_grant;
    logic              do_reject;
    logic              do_ignore;
    logic              do_clear;
    logic              do_load;

    assign cls_ok = (int'(card_class) < NUM_CLASSES);
    assign d0     = ^(sel_lfsr & LFSR_TAPS);

    always_comb begin
        sel_lfsr  = '0;
        sel_cur   = '0;
        nxt_lfsr  = '0;
        do_grant  = 1'b0;
        do_reject = 1'b0;
        do_ignore = 1'b0;
        do_clear  = 1'b0;
        do_load   = 1'b0;
        if (cls_ok) begin
            sel_lfsr = lfsr[card_class];
            sel_cur  = cur[card_class];
        end
        // First matching rule wins; lockout swallows the read entirely
        if (card_strobe) begin
            if (locked_out) begin
                do_ignore = 1'b1;
            end else if (!cls_ok || card_code == '0) begin
                do_reject = 1'b1;
            end else if (card_is_reset) begin
                if (card_code == RESET_CODE) do_clear  = 1'b1;
                else                         do_reject = 1'b1;
            end else if (sel_lfsr == '0) begin
                do_grant = 1'b1;
                do_load  = 1'b1;
                nxt_lfsr = card_code;
            end else if (card_code == sel_lfsr) begin
                do_grant = 1'b1;
                do_load  = 1'b1;
                nxt_lfsr = {sel_lfsr[CODE_W-2:0], d0};
            end else if (card_code == sel_cur) begin
                do_grant = 1'b1;
            end else begin
                do_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                lfsr[c] <= '0;
                cur[c]  <= '0;
            end
            fail_cnt    <= '0;
            open_cnt    <= '0;
            lock_cnt    <= '0;
            unlock      <= 1'b0;
            grant_class <= '0;
            reject      <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            reject <= do_reject | do_ignore;

            if (do_load) begin
                lfsr[card_class] <= nxt_lfsr;
                cur[card_class]  <= card_code;
            end else if (do_clear) begin
                lfsr[card_class] <= '0;
                cur[card_class]  <= '0;
            end

            if (do_grant) begin
                grant_class <= card_class;
                open_cnt    <= OPEN_LD;
                unlock      <= 1'b1;
            end else begin
                open_cnt <= (open_cnt != '0) ? open_cnt - OPEN_1 : '0;
                unlock   <= (open_cnt > OPEN_1);
            end

            if (do_reject && fail_cnt == FAIL_LAST) begin
                fail_cnt   <= '0;
                lock_cnt   <= LOCK_LD;
                locked_out <= 1'b1;
            end else begin
                if (do_reject)                fail_cnt <= fail_cnt + FAIL_1;
                else if (do_grant | do_clear) fail_cnt <= '0;
                lock_cnt   <= (lock_cnt != '0) ? lock_cnt - LOCK_1 : '0;
                locked_out <= (lock_cnt > LOCK_1);
            end
        end
    end

endmodule
